// File: rtl/clk_switch_sequencer.sv
// Glitch-safe reconfiguration sequencer for a two-channel clock divider/selector.
// Gates the output while the active clock is low, loads the factor, and re-enables after a fresh low phase on the target.
module clk_switch_sequencer #(
  parameter int DIV_W   = 3,
  parameter int TO_W    = 6,
  parameter int DIV_RST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sel,
  input  logic [DIV_W-1:0] req_div,
  input  logic             req_en,
  input  logic             clk_a_in,
  input  logic             clk_b_in,
  output logic             out_en,
  output logic             out_sel,
  output logic [DIV_W-1:0] div_a,
  output logic [DIV_W-1:0] div_b,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] GATE = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] SYNC = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

  logic [2:0]       state;
  logic [TO_W-1:0]  cnt;
  logic             edge_r;
  logic             cap_sel;
  logic             cap_en;
  logic [DIV_W-1:0] cap_div;

  logic act, tgt, accept, noop, term, fall, gate_ok;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign act       = out_sel ? clk_a_in : clk_b_in;
  assign tgt       = cap_sel ? clk_a_in : clk_b_in;
  assign accept    = req_valid && req_ready;
  assign noop      = req_en && out_en && (req_sel == out_sel) &&
                     (req_div == (req_sel ? div_a : div_b));
  assign term      = &cnt;
  assign fall      = edge_r & ~tgt;
  // Normal gate condition wins over a coincident terminal count
  assign gate_ok   = ~out_en | ~act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_en  <= 1'b0;
      out_sel <= 1'b0;
      div_a   <= DIV_W'(DIV_RST);
      div_b   <= DIV_W'(DIV_RST);
      done    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      edge_r  <= 1'b0;
      cap_sel <= 1'b0;
      cap_en  <= 1'b0;
      cap_div <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cap_sel <= req_sel;
          cap_div <= req_div;
          cap_en  <= req_en;
          if (noop) done <= 1'b1;
          else begin
            state <= GATE;
            cnt   <= '0;
          end
        end
        GATE: if (gate_ok || term) begin
          out_en <= 1'b0;
          if (!gate_ok) err <= 1'b1;
          if (cap_en) state <= LOAD;
          else begin
            state <= FIN;
            done  <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        LOAD: begin
          if (cap_sel) div_a <= cap_div;
          else         div_b <= cap_div;
          out_sel <= cap_sel;
          edge_r  <= tgt;
          cnt     <= '0;
          state   <= SYNC;
        end
        SYNC: begin
          edge_r <= tgt;
          if (fall || term) begin
            if (!fall) err <= 1'b1;
            out_en <= 1'b1;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Directed bench for clk_switch_sequencer: cycle-accurate vector table plus timeout and reset sequences.
module tb_clk_switch_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_sel, req_en;
  logic [2:0] req_div;
  logic       clk_a_in, clk_b_in;
  logic       req_ready, out_en, out_sel, busy, done, err;
  logic [2:0] div_a, div_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic tgl_en = 1'b0;
  int   tgl_cnt = 0;

  clk_switch_sequencer #(.DIV_W(3), .TO_W(6), .DIV_RST(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_div(req_div), .req_en(req_en),
    .clk_a_in(clk_a_in), .clk_b_in(clk_b_in), .out_en(out_en), .out_sel(out_sel),
    .div_a(div_a), .div_b(div_b), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, s;
    logic [2:0] d;
    logic       e, a, b;
    logic       oe, os, bz, dn, er;
    logic [2:0] da, db;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(logic v, logic s, logic [2:0] d, logic e, logic a, logic b,
                              logic oe, logic os, logic bz, logic dn, logic er,
                              logic [2:0] da, logic [2:0] db);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.e = e; t.a = a; t.b = b;
    t.oe = oe; t.os = os; t.bz = bz; t.dn = dn; t.er = er; t.da = da; t.db = db;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one clock; optional toggling of both observed clocks every 3 cycles
  task automatic step();
    @(posedge clk);
    #1;
    if (tgl_en) begin
      tgl_cnt++;
      if (tgl_cnt == 3) begin
        tgl_cnt  = 0;
        clk_a_in = ~clk_a_in;
        clk_b_in = ~clk_b_in;
      end
    end
  endtask

  // Issue a request from IDLE and count cycles after accept until done (0 = never)
  task automatic do_req(input logic s, input logic [2:0] d, input logic e, input int bound,
                        output int n);
    step();
    req_valid = 1'b1; req_sel = s; req_div = d; req_en = e;
    step();
    req_valid = 1'b0;
    n = 0;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  function automatic logic [10:0] pack_out();
    return {out_en, out_sel, busy, done, err, div_a, div_b};
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_sel = 1'b0; req_div = 3'd0; req_en = 1'b0;
    clk_a_in = 1'b0; clk_b_in = 1'b0;

    tbl[0]  = mk(1,1,3,1,0,0, 0,0,1,0,0, 0,0);
    tbl[1]  = mk(0,0,0,0,0,0, 0,0,1,0,0, 0,0);
    tbl[2]  = mk(0,0,0,0,0,0, 0,1,1,0,0, 3,0);
    tbl[3]  = mk(0,0,0,0,1,0, 0,1,1,0,0, 3,0);
    tbl[4]  = mk(0,0,0,0,1,0, 0,1,1,0,0, 3,0);
    tbl[5]  = mk(0,0,0,0,0,0, 1,1,1,1,0, 3,0);
    tbl[6]  = mk(0,0,0,0,0,0, 1,1,0,0,0, 3,0);
    tbl[7]  = mk(1,1,3,1,1,0, 1,1,0,1,0, 3,0);
    tbl[8]  = mk(0,0,0,0,1,0, 1,1,0,0,0, 3,0);
    tbl[9]  = mk(1,0,5,1,1,0, 1,1,1,0,0, 3,0);
    tbl[10] = mk(0,0,0,0,1,0, 1,1,1,0,0, 3,0);
    tbl[11] = mk(0,0,0,0,1,0, 1,1,1,0,0, 3,0);
    tbl[12] = mk(0,0,0,0,1,0, 1,1,1,0,0, 3,0);
    tbl[13] = mk(0,0,0,0,0,0, 0,1,1,0,0, 3,0);
    tbl[14] = mk(0,0,0,0,0,1, 0,0,1,0,0, 3,5);
    tbl[15] = mk(0,0,0,0,0,1, 0,0,1,0,0, 3,5);
    tbl[16] = mk(0,0,0,0,0,0, 1,0,1,1,0, 3,5);
    tbl[17] = mk(0,0,0,0,0,0, 1,0,0,0,0, 3,5);
    tbl[18] = mk(1,0,7,0,0,1, 1,0,1,0,0, 3,5);
    tbl[19] = mk(1,1,2,1,0,1, 1,0,1,0,0, 3,5);
    tbl[20] = mk(0,0,0,0,0,0, 0,0,1,1,0, 3,5);
    tbl[21] = mk(0,0,0,0,0,0, 0,0,0,0,0, 3,5);
    tbl[22] = mk(1,1,0,1,1,0, 0,0,1,0,0, 3,5);
    tbl[23] = mk(0,0,0,0,1,1, 0,0,1,0,0, 3,5);
    tbl[24] = mk(0,0,0,0,1,1, 0,1,1,0,0, 0,5);
    tbl[25] = mk(0,0,0,0,0,1, 1,1,1,1,0, 0,5);
    tbl[26] = mk(0,0,0,0,0,1, 1,1,0,0,0, 0,5);

    #23;
    chk("reset_state", {pack_out(), req_ready}, 12'h001);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 27; i++) begin
      req_valid = tbl[i].v; req_sel = tbl[i].s; req_div = tbl[i].d; req_en = tbl[i].e;
      clk_a_in = tbl[i].a; clk_b_in = tbl[i].b;
      step();
      chk($sformatf("row%0d", i), pack_out(),
          {tbl[i].oe, tbl[i].os, tbl[i].bz, tbl[i].dn, tbl[i].er, tbl[i].da, tbl[i].db});
    end

    // SYNC timeout: target stuck high, act low so GATE passes immediately
    clk_a_in = 1'b0; clk_b_in = 1'b1;
    do_req(1'b0, 3'd2, 1'b1, 100, n);
    chk("timeout_latency", n, 66);
    chk("timeout_outs", {out_en, out_sel, err, div_a, div_b}, {1'b1, 1'b0, 1'b1, 3'd0, 3'd2});

    // Good request after timeout: err remains sticky
    tgl_en = 1'b1;
    do_req(1'b1, 3'd4, 1'b1, 40, n);
    chk("good_done_seen", (n > 0), 1);
    chk("good_outs", {out_en, out_sel, err, div_a, div_b}, {1'b1, 1'b1, 1'b1, 3'd4, 3'd2});

    // Reset while in SYNC
    tgl_en = 1'b0;
    step();
    clk_a_in = 1'b0; clk_b_in = 1'b1;
    req_valid = 1'b1; req_sel = 1'b0; req_div = 3'd6; req_en = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("sync_busy", {busy, out_en}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {pack_out(), req_ready}, 12'h001);
    #3 rst_n = 1'b1;
    step();
    chk("ready_after_reset", req_ready, 1);
    tgl_en = 1'b1;
    do_req(1'b1, 3'd3, 1'b1, 40, n);
    chk("post_reset_done_seen", (n > 0), 1);
    chk("post_reset_outs", {out_en, out_sel, err, div_a, div_b}, {1'b1, 1'b1, 1'b0, 3'd3, 3'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_switch_sequencer.md
Name: clk_switch_sequencer

Overview:
- Controller for the two-channel clock divider/selector.
- Accepts reconfiguration requests (target channel, divide factor, enable) over a valid/ready handshake.
- Drives the divider's select, enable and per-channel divide-factor inputs in a glitch-safe order:
  - gate the output while the active divided clock is low;
  - load the new factor;
  - wait for the target divided clock to complete a fresh low phase;
  - re-enable.
- Monitors the divided clocks (generated from clk, so synchronous to it) and flags timeouts.

Parameters:
- DIV_W, 3, width of each divide-factor field.
- TO_W, 6, width of the timeout counter; timeout fires at count 2^TO_W-1 (63).
- DIV_RST, 0, reset value of div_a and div_b.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_sel  in  1  target channel: 1 = channel A, 0 = channel B.
- req_div  in  DIV_W  new divide factor for the target channel.
- req_en  in  1  1 = switch and enable output; 0 = gate output only.
- clk_a_in  in  1  observed divided clock A.
- clk_b_in  in  1  observed divided clock B.
- out_en  out  1  divider enable (output gate).
- out_sel  out  1  divider channel select.
- div_a  out  DIV_W  channel A divide factor.
- div_b  out  DIV_W  channel B divide factor.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_en=0, out_sel=0, div_a=div_b=DIV_RST, done=0, err=0, timeout counter=0, edge register=0.
  - Reset mid-sequence aborts immediately; out_en goes low asynchronously.
- Terms:
  - act = out_sel ? clk_a_in : clk_b_in.
  - tgt = captured sel ? clk_a_in : clk_b_in.
  - Handshake accepted when req_valid && req_ready. On acceptance, req_sel, req_div and req_en are captured into internal registers; later input changes are ignored.
  - req_valid outside IDLE is ignored (not queued).
- IDLE:
  - On accept, if req_en=1 && out_en=1 && req_sel==out_sel && req_div equals the selected channel's factor: no-op. done pulses on the next cycle, state stays IDLE.
  - Otherwise → GATE. Timeout counter cleared.
- GATE:
  - If out_en=0 or act=0: out_en<=0; then → LOAD if captured en=1, else → FIN.
  - Otherwise increment the timeout counter. At terminal count: err<=1, out_en<=0, leave as above (forced gate).
- LOAD (1 cycle):
  - Write the captured div to div_a if captured sel=1, else to div_b. The non-target factor is untouched.
  - out_sel<=captured sel.
  - Edge register <= tgt; counter cleared. → SYNC.
- SYNC:
  - Edge register samples tgt every cycle.
  - Exit condition: a falling edge (register=1, tgt=0). On exit → FIN with out_en<=1.
  - The first sample in SYNC cannot produce an edge, because the register was preloaded in LOAD.
  - Terminal count: err<=1; → FIN with out_en<=1 anyway.
- FIN (1 cycle): done<=1 for exactly this cycle; → IDLE.
- Latency:
  - Minimum, act already low: accept at cycle 0; GATE c1, LOAD c2, SYNC from c3; out_en high and done in the cycle after the falling edge.
  - Disable request (req_en=0) with act low: done at c2.
- Width/arithmetic:
  - Timeout counter saturates at terminal count. It never wraps while in a state.
  - All factor fields are passed through unmodified. Factor 0 is legal.
- Simultaneous events:
  - Terminal count and act=0 in the same cycle count as a normal exit; err is not set.
  - Terminal count and a falling edge in the same cycle count as a normal exit; err is not set.
- out_en changes only in the GATE→next and SYNC→FIN transitions (and reset).
- out_sel and div_* change only in LOAD.

Test Plan:
- Reset, then request sel=1, div=3, en=1; clk_a_in toggles every 4 cycles → div_a=3, out_sel=1, out_en rises exactly 1 cycle after the first clk_a_in falling edge following LOAD, with done in that cycle; div_b stays 0; err=0.
- Repeat an identical request while enabled → done pulses 1 cycle after accept; busy stays 0; out_en stays 1.
- Switch to sel=0, div=5 while clk_a_in is high for 6 cycles → out_en stays 1 until clk_a_in falls, then drops; out_sel=0; div_b=5; div_a keeps 3.
- Hold clk_b_in at constant 1 during SYNC → after 63 counted cycles err=1, out_en=1, done pulses; err stays 1 through later good requests.
- Request en=0 → out_en=0 at the first cycle act is low; div_* and out_sel unchanged; done 1 cycle later.
- Assert rst_n=0 during SYNC → all outputs return to reset values immediately; after release, req_ready=1 and the next request proceeds normally.
